// File: rtl/division_unsigned_if.sv
// Start/done handshake bundle for the sequential unsigned divider.
// The requester drives the operands and start; the divider returns the quotient and status.
interface division_unsigned_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 flag;
    logic [2*WIDTH-1:0]   A;
    logic [2*WIDTH-1:0]   B;
    logic [2*WIDTH-1:0]   Result;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, flag, A, B,
        input  Result, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, flag, A, B,
        output Result, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/division_unsigned.sv
// Iterative restoring unsigned divider: one quotient bit per clock, MSB first.
// Produces a fixed-point (flag=1) or integer (flag=0) quotient, saturating on overflow.
module division_unsigned #(
    parameter int WIDTH           = 8,
    parameter int FRACTIONAL_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    division_unsigned_if.slave  bus
);
    localparam int DW = 2 * WIDTH;
    localparam int NW = DW + FRACTIONAL_BITS;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    state_t          state_r;
    logic [NW-1:0]   dividend_r;
    logic [DW-1:0]   divisor_r;
    logic [DW:0]     rem_r;
    logic [NW-1:0]   quot_r;
    logic [CW-1:0]   count_r;
    logic [DW-1:0]   result_r;
    logic            busy_r;
    logic            done_r;
    logic            dz_r;
    logic            ov_r;

    logic [DW:0]     rem_shift_s;
    logic [DW:0]     rem_next_s;
    logic            qbit_s;
    logic [NW-1:0]   quot_next_s;
    logic            ovf_s;

    // One restoring step; the remainder stays below B, so its top bit is free for the shift.
    always_comb begin
        rem_shift_s = {rem_r[DW-1:0], dividend_r[NW-1]};
        rem_next_s  = rem_shift_s;
        qbit_s      = 1'b0;
        if (rem_shift_s >= {1'b0, divisor_r}) begin
            rem_next_s = rem_shift_s - {1'b0, divisor_r};
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = rem_shift_s;
            qbit_s     = 1'b0;
        end
        quot_next_s = {quot_r[NW-2:0], qbit_s};
        ovf_s       = |(quot_next_s >> DW);
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            dividend_r <= '0;
            divisor_r  <= '0;
            rem_r      <= '0;
            quot_r     <= '0;
            count_r    <= '0;
            result_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dz_r       <= 1'b0;
            ov_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.flag) begin
                            dividend_r <= {bus.A, {FRACTIONAL_BITS{1'b0}}};
                        end else begin
                            dividend_r <= {{FRACTIONAL_BITS{1'b0}}, bus.A};
                        end
                        divisor_r <= bus.B;
                        rem_r     <= '0;
                        quot_r    <= '0;
                        count_r   <= '0;
                        busy_r    <= 1'b1;
                        dz_r      <= 1'b0;
                        ov_r      <= 1'b0;
                        state_r   <= (bus.B == '0) ? S_ZERO : S_RUN;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_r      <= rem_next_s;
                    quot_r     <= quot_next_s;
                    dividend_r <= dividend_r << 1;
                    count_r    <= count_r + CW'(1);
                    if (count_r == CW'(NW - 1)) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        // Quotient bits above the result width mean saturation.
                        if (ovf_s) begin
                            result_r <= '1;
                            ov_r     <= 1'b1;
                        end else begin
                            result_r <= quot_next_s[DW-1:0];
                            ov_r     <= 1'b0;
                        end
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_ZERO: begin
                    result_r <= '1;
                    dz_r     <= 1'b1;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Result      = result_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.overflow    = ov_r;
endmodule

// File: tb/tb_division_unsigned.sv
// Scoreboard bench for division_unsigned: stimulus pushes expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_division_unsigned;
    localparam int WIDTH = 8;
    localparam int LAT   = 24;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   cyc;

    typedef struct {
        string       name;
        logic [15:0] result;
        logic        dz;
        logic        ov;
        int          done_cyc;
    } exp_t;

    exp_t sb_q[$];

    division_unsigned_if #(.WIDTH(WIDTH)) dif ();

    division_unsigned #(.WIDTH(WIDTH), .FRACTIONAL_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dif.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_result"}, {16'd0, dif.Result}, {16'd0, e.result});
                check({e.name, "_dz"}, {31'd0, dif.div_by_zero}, {31'd0, e.dz});
                check({e.name, "_ov"}, {31'd0, dif.overflow}, {31'd0, e.ov});
                check({e.name, "_latency"}, cyc, e.done_cyc);
                check({e.name, "_busy_low"}, {31'd0, dif.busy}, 32'd0);
            end
        end
    end

    task automatic issue(input string name, input logic f, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic edz, input logic eov, input int lat,
                         input bit push);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (dif.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check({name, "_wait_idle_timeout"}, 32'd1, 32'd0);
        dif.start = 1'b1;
        dif.flag  = f;
        dif.A     = a;
        dif.B     = b;
        if (push) begin
            e.name = name; e.result = er; e.dz = edz; e.ov = eov; e.done_cyc = cyc + 1 + lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drain"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        checks = 0; fails = 0; cyc = 0;
        rst = 1'b1;
        dif.start = 1'b0; dif.flag = 1'b0; dif.A = 16'd0; dif.B = 16'd0;
        #1;
        check("reset_result", {16'd0, dif.Result}, 32'd0);
        check("reset_busy", {31'd0, dif.busy}, 32'd0);
        check("reset_done", {31'd0, dif.done}, 32'd0);
        check("reset_flags", {30'd0, dif.div_by_zero, dif.overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fixed-point set, issued back-to-back
        issue("fx_119_10", 1'b1, 16'd119, 16'd10, 16'h0BE6, 1'b0, 1'b0, LAT, 1'b1);
        issue("fx_211_40", 1'b1, 16'd211, 16'd40, 16'h0546, 1'b0, 1'b0, LAT, 1'b1);
        issue("fx_91_9",   1'b1, 16'd91,  16'd9,  16'h0A1C, 1'b0, 1'b0, LAT, 1'b1);
        issue("fx_71_10",  1'b1, 16'd71,  16'd10, 16'h0719, 1'b0, 1'b0, LAT, 1'b1);
        issue("fx_16_3",   1'b1, 16'd16,  16'd3,  16'h0555, 1'b0, 1'b0, LAT, 1'b1);
        issue("fx_255_11", 1'b1, 16'd255, 16'd11, 16'h172E, 1'b0, 1'b0, LAT, 1'b1);
        issue("fx_1_4",    1'b1, 16'd1,   16'd4,  16'h0040, 1'b0, 1'b0, LAT, 1'b1);

        // Integer mode
        issue("int_119_10",  1'b0, 16'd119,   16'd10, 16'd11,    1'b0, 1'b0, LAT, 1'b1);
        issue("int_65535_1", 1'b0, 16'd65535, 16'd1,  16'd65535, 1'b0, 1'b0, LAT, 1'b1);
        issue("int_5_7",     1'b0, 16'd5,     16'd7,  16'd0,     1'b0, 1'b0, LAT, 1'b1);

        // Boundaries
        issue("fx_ovf",     1'b1, 16'd65535, 16'd1, 16'hFFFF, 1'b0, 1'b1, LAT, 1'b1);
        issue("fx_divzero", 1'b1, 16'd7,     16'd0, 16'hFFFF, 1'b1, 1'b0, 1,   1'b1);
        issue("int_a0",     1'b0, 16'd0,     16'd5, 16'd0,    1'b0, 1'b0, LAT, 1'b1);

        // Start while busy must be ignored
        issue("busy_first", 1'b1, 16'd119, 16'd10, 16'h0BE6, 1'b0, 1'b0, LAT, 1'b1);
        repeat (4) @(negedge clk);
        dif.start = 1'b1; dif.flag = 1'b0; dif.A = 16'd255; dif.B = 16'd11;
        @(negedge clk);
        dif.start = 1'b0;
        issue("after_busy", 1'b0, 16'd200, 16'd7, 16'd28, 1'b0, 1'b0, LAT, 1'b1);
        drain("handshake");

        // Reset mid-operation aborts without a done pulse
        issue("aborted", 1'b1, 16'd211, 16'd40, 16'h0000, 1'b0, 1'b0, LAT, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_result", {16'd0, dif.Result}, 32'd0);
        check("midrst_busy", {31'd0, dif.busy}, 32'd0);
        check("midrst_done", {31'd0, dif.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no_done_after_abort_queue", sb_q.size(), 32'd0);
        issue("post_rst_16_3", 1'b1, 16'd16, 16'd3, 16'h0555, 1'b0, 1'b0, LAT, 1'b1);
        drain("final");
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
